ara_dram_preload_ctrl: RTL and testbench

// - Synthesizable replacement for simulator back-door DRAM preload. Owns the DRAM SRAM port.
// - Boot: writes program sections, streamed as descriptors plus data rows, into DRAM.
// - Then hands the port to the SoC memory path and releases the system from hold.
// - Sits between the external loader (JTAG/DPI/host link), the SoC AXI-to-mem bridge and i_dram.

---
 rtl/ara_pkg.sv | 19 +
 rtl/ara_dram_preload_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ara_dram_preload_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ara_pkg.sv
// Shared types for the DRAM preload controller:
// FSM state encoding and the section descriptor bundle.
package ara_pkg;

  localparam int unsigned SecWidth = 64;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DRAIN,
    RUN
  } preload_state_e;

  typedef struct packed {
    logic [SecWidth-1:0] addr;
    logic [SecWidth-1:0] len;
  } preload_sec_t;

endpackage

// File: rtl/ara_dram_preload_ctrl.sv
// Boot-time DRAM loader: owns the DRAM SRAM port, writes streamed program
// sections (descriptor + data rows), then hands the port to the SoC path.
// Ports: sec_* descriptor stream, data_* row stream, load_done_i,
// sys_* SoC memory port, mem_* SRAM port, boot_done_o/err_o/rows_written_o.
module ara_dram_preload_ctrl
  import ara_pkg::*;
#(
  parameter int unsigned AddrWidth = SecWidth,
  parameter int unsigned DataWidth = 128,
  parameter logic [AddrWidth-1:0] DRAMAddrBase = 64'h8000_0000,
  parameter logic [AddrWidth-1:0] DRAMLength = 64'h4000_0000,
  parameter int unsigned MemAddrWidth = 27
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      sec_valid_i,
  output logic                      sec_ready_o,
  input  logic [AddrWidth-1:0]      sec_addr_i,
  input  logic [AddrWidth-1:0]      sec_len_i,
  input  logic                      data_valid_i,
  output logic                      data_ready_o,
  input  logic [DataWidth-1:0]      data_i,
  input  logic                      load_done_i,
  input  logic                      sys_req_i,
  output logic                      sys_gnt_o,
  input  logic                      sys_we_i,
  input  logic [MemAddrWidth-1:0]   sys_addr_i,
  input  logic [DataWidth-1:0]      sys_wdata_i,
  input  logic [DataWidth/8-1:0]    sys_be_i,
  output logic                      sys_rvalid_o,
  output logic [DataWidth-1:0]      sys_rdata_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MemAddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]      mem_wdata_o,
  output logic [DataWidth/8-1:0]    mem_be_o,
  input  logic [DataWidth-1:0]      mem_rdata_i,
  output logic                      boot_done_o,
  output logic                      err_o,
  output logic [31:0]               rows_written_o
);

  localparam int unsigned BeW = DataWidth / 8;
  localparam int unsigned ByteOffset = $clog2(BeW);
  localparam int unsigned RemWidth = SecWidth + 1;
  localparam logic [SecWidth-1:0] Base = SecWidth'(DRAMAddrBase);
  localparam logic [SecWidth-1:0] Length = SecWidth'(DRAMLength);

  typedef logic [RemWidth-1:0] rem_t;

  // Extra top bit keeps addr+len and Base+Length from wrapping.
  function automatic logic sec_in_dram(preload_sec_t s);
    rem_t sec_end;
    rem_t dram_end;
    sec_end = {1'b0, s.addr} + {1'b0, s.len};
    dram_end = {1'b0, Base} + {1'b0, Length};
    return (s.addr >= Base) && (sec_end <= dram_end) &&
           ((s.addr % SecWidth'(BeW)) == '0);
  endfunction

  preload_state_e state_q, state_d;
  logic [MemAddrWidth-1:0] row_q, row_d;
  rem_t rem_q, rem_d;
  logic rvalid_q;
  logic err_q, err_d;
  logic [31:0] cnt_q, cnt_d;

  preload_sec_t sec;
  rem_t nrows;
  logic [MemAddrWidth-1:0] row0;
  logic sec_ok;

  assign sec = '{addr: SecWidth'(sec_addr_i), len: SecWidth'(sec_len_i)};
  assign nrows = ({1'b0, sec.len} + rem_t'(BeW - 1)) >> ByteOffset;
  assign row0 = MemAddrWidth'((sec.addr - Base) >> ByteOffset);
  assign sec_ok = sec_in_dram(sec);

  always_comb begin
    state_d = state_q;
    row_d = row_q;
    rem_d = rem_q;
    err_d = err_q;
    cnt_d = cnt_q;
    sec_ready_o = 1'b0;
    data_ready_o = 1'b0;
    sys_gnt_o = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o = 1'b0;
    mem_addr_o = '0;
    mem_wdata_o = '0;
    mem_be_o = '0;
    unique case (state_q)
      IDLE: begin
        // Held low while reset is asserted so every output reads 0.
        sec_ready_o = !rst_i;
        if (sec_valid_i) begin
          if (sec.len != '0) begin
            row_d = row0;
            rem_d = nrows;
            if (sec_ok) begin
              state_d = WRITE;
            end else begin
              err_d = 1'b1;
              state_d = DRAIN;
            end
          end
        end else if (load_done_i) begin
          state_d = RUN;
        end
      end
      WRITE: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          mem_req_o = 1'b1;
          mem_we_o = 1'b1;
          mem_addr_o = row_q;
          mem_wdata_o = data_i;
          mem_be_o = '1;
          row_d = row_q + MemAddrWidth'(1);
          rem_d = rem_q - rem_t'(1);
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 32'd1;
          end
          if (rem_q == rem_t'(1)) begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          rem_d = rem_q - rem_t'(1);
          if (rem_q == rem_t'(1)) begin
            state_d = IDLE;
          end
        end
      end
      RUN: begin
        sys_gnt_o = sys_req_i;
        mem_req_o = sys_req_i;
        mem_we_o = sys_we_i;
        mem_addr_o = sys_addr_i;
        mem_wdata_o = sys_wdata_i;
        mem_be_o = sys_be_i;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      row_q <= '0;
      rem_q <= '0;
      rvalid_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      rem_q <= rem_d;
      rvalid_q <= (state_q == RUN) && sys_req_i && !sys_we_i;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign sys_rvalid_o = rvalid_q;
  assign sys_rdata_o = mem_rdata_i;
  assign boot_done_o = (state_q == RUN);
  assign err_o = err_q;
  assign rows_written_o = cnt_q;

endmodule

// File: tb/tb_ara_dram_preload_ctrl.sv
// Bench for ara_dram_preload_ctrl: table vectors, hand sequences and
// randomized sections/system traffic against a byte-level reference model.
module tb_ara_dram_preload_ctrl;

  localparam int unsigned DW = 128;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned MAW = 27;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] DLEN = 64'h4000_0000;

  logic clk = 1'b0;
  logic rst;
  logic sec_valid_i, sec_ready_o;
  logic [63:0] sec_addr_i, sec_len_i;
  logic data_valid_i, data_ready_o;
  logic [DW-1:0] data_i;
  logic load_done_i;
  logic sys_req_i, sys_gnt_o, sys_we_i;
  logic [MAW-1:0] sys_addr_i;
  logic [DW-1:0] sys_wdata_i;
  logic [BW-1:0] sys_be_i;
  logic sys_rvalid_o;
  logic [DW-1:0] sys_rdata_o;
  logic mem_req_o, mem_we_o;
  logic [MAW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [BW-1:0] mem_be_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic boot_done_o, err_o;
  logic [31:0] rows_written_o;

  always #5 clk = ~clk;

  ara_dram_preload_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .sec_valid_i(sec_valid_i), .sec_ready_o(sec_ready_o),
    .sec_addr_i(sec_addr_i), .sec_len_i(sec_len_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .data_i(data_i), .load_done_i(load_done_i),
    .sys_req_i(sys_req_i), .sys_gnt_o(sys_gnt_o), .sys_we_i(sys_we_i),
    .sys_addr_i(sys_addr_i), .sys_wdata_i(sys_wdata_i),
    .sys_be_i(sys_be_i), .sys_rvalid_o(sys_rvalid_o),
    .sys_rdata_o(sys_rdata_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i), .boot_done_o(boot_done_o),
    .err_o(err_o), .rows_written_o(rows_written_o)
  );

  typedef struct {
    logic [MAW-1:0] row;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } wr_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] len;
    bit exp_err;
    int exp_cnt;
  } vec_t;

  logic [DW-1:0] sram [int unsigned];
  logic [DW-1:0] shadow [int unsigned];
  wr_t wr_q[$];
  wr_t exp_q[$];
  bit in_run = 1'b0;
  int exp_cnt = 0;
  bit exp_err = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old,
                                          logic [DW-1:0] wd,
                                          logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] sram_rd(logic [MAW-1:0] a);
    return sram.exists(32'(a)) ? sram[32'(a)] : '0;
  endfunction

  function automatic logic [DW-1:0] shadow_rd(logic [MAW-1:0] a);
    return shadow.exists(32'(a)) ? shadow[32'(a)] : '0;
  endfunction

  task automatic sram_wr(input logic [MAW-1:0] a, input logic [DW-1:0] wd,
                         input logic [BW-1:0] be);
    sram[32'(a)] = merge(sram_rd(a), wd, be);
  endtask

  // SRAM with 1-cycle read latency; also records preload writes.
  always @(posedge clk) begin
    if (mem_req_o && mem_we_o) begin
      sram_wr(mem_addr_o, mem_wdata_o, mem_be_o);
      if (!in_run)
        wr_q.push_back('{row: mem_addr_o, data: mem_wdata_o, be: mem_be_o});
    end
    if (mem_req_o && !mem_we_o) mem_rdata_i <= sram_rd(mem_addr_o);
  end

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_rdy(input bit data_side, output int waited);
    waited = -1;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (data_side ? data_ready_o : sec_ready_o) begin
        waited = t;
        break;
      end
      @(negedge clk);
    end
    if (waited < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: ready never rose within 20 cycles",
               data_side ? "data_timeout" : "sec_timeout");
    end
  endtask

  task automatic cmp_writes();
    wr_t a, e;
    chk("wr_count", 128'(wr_q.size()), 128'(exp_q.size()));
    while (wr_q.size() > 0 && exp_q.size() > 0) begin
      a = wr_q.pop_front();
      e = exp_q.pop_front();
      chk("wr_row", 128'(a.row), 128'(e.row));
      chk("wr_data", a.data, e.data);
      chk("wr_be", 128'(a.be), 128'(e.be));
    end
    wr_q.delete();
    exp_q.delete();
  endtask

  // Model: a section is a byte string written from addr; rows are
  // BW-byte slices, zero-padded after the last byte.
  task automatic send_section(input logic [63:0] addr, input logic [63:0] len,
                              output int sec_wait);
    byte unsigned bytes[$];
    longint unsigned nrows, row0;
    bit ok;
    int w;
    logic [DW-1:0] rows[$];
    logic [DW-1:0] r;
    ok = (addr >= BASE) && (addr + len <= BASE + DLEN) && (addr % BW == 0);
    nrows = (len + BW - 1) / BW;
    row0 = (addr - BASE) / BW;
    for (longint unsigned i = 0; i < len; i++) bytes.push_back(8'($urandom));
    for (longint unsigned k = 0; k < nrows; k++) begin
      r = '0;
      for (int b = 0; b < BW; b++)
        if (k * BW + b < len) r[8*b +: 8] = bytes[k * BW + b];
      rows.push_back(r);
      if (ok) begin
        exp_q.push_back('{row: MAW'(row0 + k), data: r, be: '1});
        shadow[32'(row0 + k)] = r;
        exp_cnt++;
      end
    end
    if (len != 0 && !ok) exp_err = 1'b1;
    @(negedge clk);
    data_valid_i = 1'b0;
    sec_valid_i = 1'b1;
    sec_addr_i = addr;
    sec_len_i = len;
    wait_rdy(1'b0, sec_wait);
    @(posedge clk);
    for (int k = 0; k < rows.size(); k++) begin
      @(negedge clk);
      sec_valid_i = 1'b0;
      data_valid_i = 1'b1;
      data_i = rows[k];
      sys_req_i = 1'b1;
      sys_we_i = 1'($urandom);
      sys_addr_i = MAW'($urandom_range(0, 63));
      sys_be_i = BW'($urandom);
      sys_wdata_i = {4{$urandom}};
      wait_rdy(1'b1, w);
      chk("gnt_before_run", 128'(sys_gnt_o), 128'(0));
      @(posedge clk);
    end
    #1;
    sec_valid_i = 1'b0;
    sys_req_i = 1'b0;
    cmp_writes();
    chk("idle_sec_ready", 128'(sec_ready_o), 128'(1));
    chk("idle_data_ready", 128'(data_ready_o), 128'(0));
    chk("err", 128'(err_o), 128'(exp_err));
    chk("rows_written", 128'(rows_written_o), 128'(exp_cnt));
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {72'd0, sec_ready_o, data_ready_o, sys_gnt_o, sys_rvalid_o,
               mem_req_o, mem_we_o, boot_done_o, err_o, mem_be_o,
               rows_written_o}, 128'd0);
    chk({name, "_mem"}, {mem_wdata_o}, 128'd0);
    chk({name, "_addr"}, 128'(mem_addr_o), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    int sw, w;
    logic [63:0] a, l;
    logic [DW-1:0] r0, r1;
    bit rq, we;
    logic [MAW-1:0] ra;
    logic [DW-1:0] wd;
    logic [BW-1:0] be;

    tbl[0] = '{BASE, 64'h30, 1'b0, 3};
    tbl[1] = '{BASE + 64'h40, 64'h21, 1'b0, 6};
    tbl[2] = '{BASE + 64'h100, 64'h0, 1'b0, 6};
    tbl[3] = '{BASE + DLEN - 64'h10, 64'h10, 1'b0, 7};
    tbl[4] = '{64'h7FFF_FFF0, 64'h20, 1'b1, 7};
    tbl[5] = '{BASE + 64'h8, 64'h10, 1'b1, 7};
    tbl[6] = '{BASE + DLEN - 64'h10, 64'h20, 1'b1, 7};

    rst = 1'b1;
    sec_valid_i = 1'b0; sec_addr_i = '0; sec_len_i = '0;
    data_valid_i = 1'b0; data_i = '0; load_done_i = 1'b0;
    sys_req_i = 1'b0; sys_we_i = 1'b0; sys_addr_i = '0;
    sys_wdata_i = '0; sys_be_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_outs");
    chk("reset_rdata", sys_rdata_o, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_sec_ready", 128'(sec_ready_o), 128'(1));

    for (int i = 0; i < 7; i++) begin
      send_section(tbl[i].addr, tbl[i].len, sw);
      chk("back_to_back_accept", 128'(sw), 128'(0));
      chk("tbl_err", 128'(err_o), 128'(tbl[i].exp_err));
      chk("tbl_cnt", 128'(rows_written_o), 128'(tbl[i].exp_cnt));
    end

    // Reset in the middle of a 4-row section, after row 0 is written.
    r0 = {4{$urandom}};
    r1 = {4{$urandom}};
    @(negedge clk);
    sec_valid_i = 1'b1; sec_addr_i = BASE + 64'h200; sec_len_i = 64'h40;
    wait_rdy(1'b0, w);
    @(posedge clk);
    @(negedge clk);
    sec_valid_i = 1'b0; data_valid_i = 1'b1; data_i = r0;
    wait_rdy(1'b1, w);
    @(posedge clk);
    exp_q.push_back('{row: MAW'(32), data: r0, be: '1});
    shadow[32] = r0;
    @(negedge clk);
    data_i = r1;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_async_outs");
    @(posedge clk);
    #1;
    chk_all_zero("rst_edge_outs");
    cmp_writes();
    exp_cnt = 0;
    exp_err = 1'b0;
    @(negedge clk);
    data_valid_i = 1'b0;
    rst = 1'b0;
    send_section(BASE + 64'h200, 64'h40, sw);

    for (int i = 0; i < 40; i++) begin
      l = 64'($urandom_range(0, 80));
      a = BASE + 64'($urandom_range(0, 63)) * 16;
      case ($urandom_range(0, 9))
        6: a = a + 64'($urandom_range(1, 15));
        7: a = BASE - 64'($urandom_range(1, 4)) * 16;
        8: a = BASE + DLEN - 64'($urandom_range(0, 3)) * 16;
        9: a = BASE + DLEN + 64'h10;
        default: ;
      endcase
      send_section(a, l, sw);
    end

    @(negedge clk);
    load_done_i = 1'b1;
    in_run = 1'b1;
    @(posedge clk);
    #1;
    chk("boot_done", 128'(boot_done_o), 128'(1));
    chk("run_sec_ready", 128'(sec_ready_o), 128'(0));
    chk("run_data_ready", 128'(data_ready_o), 128'(0));

    @(negedge clk);
    sys_req_i = 1'b1; sys_we_i = 1'b0; sys_addr_i = MAW'(5);
    #1;
    chk("run_gnt", 128'(sys_gnt_o), 128'(1));
    chk("run_mem_addr", 128'(mem_addr_o), 128'(5));
    @(posedge clk);
    #1;
    chk("row5_rvalid", 128'(sys_rvalid_o), 128'(1));
    chk("row5_rdata", sys_rdata_o, shadow_rd(MAW'(5)));

    for (int i = 0; i < 200; i++) begin
      rq = 1'($urandom_range(0, 3) != 0);
      we = 1'($urandom);
      ra = MAW'($urandom_range(0, 63));
      wd = {4{$urandom}};
      be = BW'($urandom);
      @(negedge clk);
      sys_req_i = rq; sys_we_i = we; sys_addr_i = ra;
      sys_wdata_i = wd; sys_be_i = be;
      #1;
      chk("sys_gnt", 128'(sys_gnt_o), 128'(rq));
      chk("sys_mem_req", 128'(mem_req_o), 128'(rq));
      @(posedge clk);
      #1;
      chk("sys_rvalid", 128'(sys_rvalid_o), 128'(rq && !we));
      if (rq && !we) chk("sys_rdata", sys_rdata_o, shadow_rd(ra));
      if (rq && we) shadow[32'(ra)] = merge(shadow_rd(ra), wd, be);
    end
    chk("boot_done_held", 128'(boot_done_o), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
